id_ex_stage: RTL and testbench

//  ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection, bubble insertion,

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/id_ex_stage_if.sv | 57 +++++
 rtl/id_ex_stage_hazard_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the MIPS pipeline ID/EX stage.
// Holds the ALUOp encodings, the control-bit bundle carried down the
// pipe, the full ID/EX register image and the WB->ID write-through rule.
package cpu_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // lw / sw / addi address and immediate add
    ALUOP_SUB   = 2'b01,  // beq compare
    ALUOP_RTYPE = 2'b10,  // decode from funct
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(9'd0);

  // Everything the ID/EX register holds for one EX entry.
  typedef struct packed {
    ctrl_t       ctrl;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  waddr;
    logic [5:0]  funct;
  } stage_t;

  // A bubble carries no control and drives zero on every data field.
  localparam stage_t STAGE_BUBBLE = stage_t'('0);

  // Register file write-through: a same-cycle WB write to the register
  // being read wins over the stale read data. $0 is hard-wired and never
  // forwarded.
  function automatic logic [31:0] wb_bypass(
    input logic [31:0] rd_data,
    input logic [4:0]  rd_addr,
    input logic        wb_we,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data
  );
    return (wb_we && (wb_addr != REG_ZERO) && (wb_addr == rd_addr)) ? wb_data : rd_data;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX pipeline bus.
// *_i signals come from the ID stage (decoded operands, control, WB
// write-back port); *_o signals are the registered EX-side copies.
// master: the ID side (drives *_i, observes *_o).
// slave : the ID/EX register (consumes *_i, drives *_o).
interface id_ex_stage_if;

  // ID side
  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] RSdata_i;
  logic [31:0] RTdata_i;
  logic [31:0] imm_i;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic [4:0]  RDaddr_i;
  logic        use_rt_i;
  logic        RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic        wb_RegWrite_i;
  logic [4:0]  wb_RegWaddr_i;
  logic [31:0] wb_data_i;

  // EX side
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] RSdata_o;
  logic [31:0] RTdata_o;
  logic [31:0] imm_o;
  logic [4:0]  RSaddr_o;
  logic [4:0]  RTaddr_o;
  logic [4:0]  RDaddr_o;
  logic [4:0]  RegWaddr_o;
  logic        RegWrite_o, MemtoReg_o, Branch_o, MemRead_o, MemWrite_o, RegDst_o, ALUSrc_o;
  logic [1:0]  ALUOp_o;
  logic [5:0]  funct_o;

  modport master (
    output valid_i, pc_i, RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i, use_rt_i,
           RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i,
           ALUOp_i, funct_i, wb_RegWrite_i, wb_RegWaddr_i, wb_data_i,
    input  valid_o, pc_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o, RDaddr_o, RegWaddr_o,
           RegWrite_o, MemtoReg_o, Branch_o, MemRead_o, MemWrite_o, RegDst_o, ALUSrc_o,
           ALUOp_o, funct_o
  );

  modport slave (
    input  valid_i, pc_i, RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i, use_rt_i,
           RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i,
           ALUOp_i, funct_i, wb_RegWrite_i, wb_RegWaddr_i, wb_data_i,
    output valid_o, pc_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o, RDaddr_o, RegWaddr_o,
           RegWrite_o, MemtoReg_o, Branch_o, MemRead_o, MemWrite_o, RegDst_o, ALUSrc_o,
           ALUOp_o, funct_o
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare.
// Flags when the load now in EX writes a register the ID instruction reads.
// Ports:
//   i_ex_valid, i_ex_mem_read, i_ex_waddr : EX entry (registered ID/EX state)
//   i_id_valid, i_id_rs, i_id_rt, i_id_use_rt : ID instruction
//   o_haz : combinational hazard flag
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_waddr,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rt,
  output logic       o_haz
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_ex_waddr == i_id_rs);
  // rt only matters when the instruction actually reads it (not for addi/lw).
  assign w_rt_hit = i_id_use_rt && (i_ex_waddr == i_id_rt);

  // A load into $0 produces nothing to wait for.
  assign o_haz = i_ex_valid && i_ex_mem_read && (i_ex_waddr != REG_ZERO) && i_id_valid
              && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Captures decoded operands and control each cycle, inserts a bubble on
// load-use hazard (stalling PC and IF/ID via stall_o) or on a taken branch
// (flush_i), and forwards a same-cycle WB write into the captured operands.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-low reset
//   start_i           : 0 freezes all state and suppresses stall_o
//   flush_i           : branch taken in MEM, kill the ID entry
//   bus (slave)       : ID-side inputs and registered EX-side outputs
//   stall_o           : combinational, hold PC and IF/ID this cycle
//   stall_cnt_o       : saturating count of stall cycles
//   flush_cnt_o       : saturating count of flushed valid entries
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  id_ex_stage_if.slave      bus,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  stage_t           r_stage;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  stage_t w_capture;
  ctrl_t  w_ctrl_in;
  logic   w_haz;

  hazard_detect u_hazard_detect (
    .i_ex_valid   (r_stage.valid),
    .i_ex_mem_read(r_stage.ctrl.mem_read),
    .i_ex_waddr   (r_stage.waddr),
    .i_id_valid   (bus.valid_i),
    .i_id_rs      (bus.RSaddr_i),
    .i_id_rt      (bus.RTaddr_i),
    .i_id_use_rt  (bus.use_rt_i),
    .o_haz        (w_haz)
  );

  // A flush outranks the hazard: the stalled instruction is being killed anyway.
  assign stall_o = w_haz && start_i && !flush_i;

  assign w_ctrl_in = '{reg_write : bus.RegWrite_i,
                       mem_to_reg: bus.MemtoReg_i,
                       branch    : bus.Branch_i,
                       mem_read  : bus.MemRead_i,
                       mem_write : bus.MemWrite_i,
                       reg_dst   : bus.RegDst_i,
                       alu_src   : bus.ALUSrc_i,
                       alu_op    : alu_op_e'(bus.ALUOp_i)};

  always_comb begin
    // NOTE: every field gets a value before any condition so no latch is inferred.
    w_capture         = STAGE_BUBBLE;
    w_capture.valid   = bus.valid_i;
    // An invalid ID slot must never write anything downstream.
    w_capture.ctrl    = bus.valid_i ? w_ctrl_in : CTRL_BUBBLE;
    w_capture.pc      = bus.pc_i;
    w_capture.rs_data = wb_bypass(bus.RSdata_i, bus.RSaddr_i, bus.wb_RegWrite_i,
                                  bus.wb_RegWaddr_i, bus.wb_data_i);
    w_capture.rt_data = wb_bypass(bus.RTdata_i, bus.RTaddr_i, bus.wb_RegWrite_i,
                                  bus.wb_RegWaddr_i, bus.wb_data_i);
    w_capture.imm     = bus.imm_i;
    w_capture.rs_addr = bus.RSaddr_i;
    w_capture.rt_addr = bus.RTaddr_i;
    w_capture.rd_addr = bus.RDaddr_i;
    w_capture.waddr   = bus.RegDst_i ? bus.RDaddr_i : bus.RTaddr_i;
    w_capture.funct   = bus.funct_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stage     <= STAGE_BUBBLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (start_i) begin
      if (flush_i) begin
        r_stage <= STAGE_BUBBLE;
        if (bus.valid_i && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (w_haz) begin
        // ID is held by stall_o, so the same instruction re-presents next cycle.
        r_stage <= STAGE_BUBBLE;
        if (!(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_stage <= w_capture;
      end
    end
  end

  assign stall_cnt_o    = r_stall_cnt;
  assign flush_cnt_o    = r_flush_cnt;

  assign bus.valid_o    = r_stage.valid;
  assign bus.pc_o       = r_stage.pc;
  assign bus.RSdata_o   = r_stage.rs_data;
  assign bus.RTdata_o   = r_stage.rt_data;
  assign bus.imm_o      = r_stage.imm;
  assign bus.RSaddr_o   = r_stage.rs_addr;
  assign bus.RTaddr_o   = r_stage.rt_addr;
  assign bus.RDaddr_o   = r_stage.rd_addr;
  assign bus.RegWaddr_o = r_stage.waddr;
  assign bus.funct_o    = r_stage.funct;
  assign bus.RegWrite_o = r_stage.ctrl.reg_write;
  assign bus.MemtoReg_o = r_stage.ctrl.mem_to_reg;
  assign bus.Branch_o   = r_stage.ctrl.branch;
  assign bus.MemRead_o  = r_stage.ctrl.mem_read;
  assign bus.MemWrite_o = r_stage.ctrl.mem_write;
  assign bus.RegDst_o   = r_stage.ctrl.reg_dst;
  assign bus.ALUSrc_o   = r_stage.ctrl.alu_src;
  assign bus.ALUOp_o    = r_stage.ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Counters are built 4 bits wide so
// saturation is reachable in a few dozen cycles.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i, start_i, flush_i;
  logic          stall_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  id_ex_stage_if bus ();

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .bus        (bus),
    .stall_o    (stall_o),
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_clear();
    bus.valid_i = 0; bus.pc_i = 0; bus.RSdata_i = 0; bus.RTdata_i = 0; bus.imm_i = 0;
    bus.RSaddr_i = 0; bus.RTaddr_i = 0; bus.RDaddr_i = 0; bus.use_rt_i = 0;
    bus.RegWrite_i = 0; bus.MemtoReg_i = 0; bus.Branch_i = 0; bus.MemRead_i = 0;
    bus.MemWrite_i = 0; bus.RegDst_i = 0; bus.ALUSrc_i = 0; bus.ALUOp_i = 0; bus.funct_i = 0;
    bus.wb_RegWrite_i = 0; bus.wb_RegWaddr_i = 0; bus.wb_data_i = 0;
  endtask

  task automatic drive_random();
    bus.valid_i = 1'($urandom); bus.pc_i = $urandom; bus.RSdata_i = $urandom;
    bus.RTdata_i = $urandom; bus.imm_i = $urandom; bus.RSaddr_i = 5'($urandom);
    bus.RTaddr_i = 5'($urandom); bus.RDaddr_i = 5'($urandom); bus.use_rt_i = 1'($urandom);
    bus.RegWrite_i = 1'($urandom); bus.MemtoReg_i = 1'($urandom); bus.Branch_i = 1'($urandom);
    bus.MemRead_i = 1'($urandom); bus.MemWrite_i = 1'($urandom); bus.RegDst_i = 1'($urandom);
    bus.ALUSrc_i = 1'($urandom); bus.ALUOp_i = 2'($urandom); bus.funct_i = 6'($urandom);
    bus.wb_RegWrite_i = 1'($urandom); bus.wb_RegWaddr_i = 5'($urandom); bus.wb_data_i = $urandom;
    start_i = 1'($urandom); flush_i = 1'($urandom);
  endtask

  // R-type add: reads rs and rt, writes rd.
  task automatic drive_rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] rsd, input logic [31:0] rtd);
    bus.valid_i = 1; bus.RSaddr_i = rs; bus.RTaddr_i = rt; bus.RDaddr_i = rd;
    bus.RSdata_i = rsd; bus.RTdata_i = rtd; bus.use_rt_i = 1;
    bus.RegWrite_i = 1; bus.MemtoReg_i = 0; bus.Branch_i = 0; bus.MemRead_i = 0;
    bus.MemWrite_i = 0; bus.RegDst_i = 1; bus.ALUSrc_i = 0; bus.ALUOp_i = 2'b10;
    bus.funct_i = 6'h20;
  endtask

  // lw rt, 0(rs)
  task automatic drive_lw(input logic [4:0] rt, input logic [4:0] rs);
    bus.valid_i = 1; bus.RSaddr_i = rs; bus.RTaddr_i = rt; bus.RDaddr_i = 0;
    bus.RSdata_i = 32'h100; bus.RTdata_i = 0; bus.use_rt_i = 0; bus.imm_i = 0;
    bus.RegWrite_i = 1; bus.MemtoReg_i = 1; bus.Branch_i = 0; bus.MemRead_i = 1;
    bus.MemWrite_i = 0; bus.RegDst_i = 0; bus.ALUSrc_i = 1; bus.ALUOp_i = 2'b00;
    bus.funct_i = 0;
  endtask

  // addi rt, rs, imm
  task automatic drive_addi(input logic [4:0] rt, input logic [4:0] rs);
    bus.valid_i = 1; bus.RSaddr_i = rs; bus.RTaddr_i = rt; bus.RDaddr_i = 0;
    bus.RSdata_i = 32'h9; bus.RTdata_i = 0; bus.use_rt_i = 0; bus.imm_i = 32'h4;
    bus.RegWrite_i = 1; bus.MemtoReg_i = 0; bus.Branch_i = 0; bus.MemRead_i = 0;
    bus.MemWrite_i = 0; bus.RegDst_i = 0; bus.ALUSrc_i = 1; bus.ALUOp_i = 2'b00;
    bus.funct_i = 0;
  endtask

  initial begin
    // ---- reset with random inputs
    rst_i = 0;
    drive_random();
    step();
    drive_random();
    step();
    check("rst_valid", 32'(bus.valid_o), 0);
    check("rst_ctrl", 32'({bus.RegWrite_o, bus.MemtoReg_o, bus.Branch_o, bus.MemRead_o,
                           bus.MemWrite_o, bus.RegDst_o, bus.ALUSrc_o, bus.ALUOp_o}), 0);
    check("rst_data_or", 32'(|{bus.pc_o, bus.RSdata_o, bus.RTdata_o, bus.imm_o, bus.RSaddr_o,
                               bus.RTaddr_o, bus.RDaddr_o, bus.RegWaddr_o, bus.funct_o}), 0);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_stall_cnt", 32'(stall_cnt_o), 0);
    check("rst_flush_cnt", 32'(flush_cnt_o), 0);

    rst_i = 1; start_i = 1; flush_i = 0;
    drive_clear();
    step();

    // ---- pass-through: add $3,$1,$2
    drive_rtype(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
    bus.pc_i = 32'h104; bus.imm_i = 32'h1820;
    settle();
    check("pt_stall", 32'(stall_o), 0);
    step();
    check("pt_waddr", 32'(bus.RegWaddr_o), 3);
    check("pt_rsdata", bus.RSdata_o, 5);
    check("pt_rtdata", bus.RTdata_o, 7);
    check("pt_regwrite", 32'(bus.RegWrite_o), 1);
    check("pt_valid", 32'(bus.valid_o), 1);
    check("pt_aluop", 32'(bus.ALUOp_o), 2);
    check("pt_pc", bus.pc_o, 32'h104);
    check("pt_imm", bus.imm_o, 32'h1820);
    check("pt_funct", 32'(bus.funct_o), 32'h20);

    // ---- load-use on rs: lw $4 ; add $5,$4,$1
    drive_lw(5'd4, 5'd1);
    step();
    check("lw_waddr", 32'(bus.RegWaddr_o), 4);
    check("lw_memread", 32'(bus.MemRead_o), 1);
    drive_rtype(5'd5, 5'd4, 5'd1, 32'h11, 32'h22);
    settle();
    check("lu_stall", 32'(stall_o), 1);
    step();
    check("lu_bubble_valid", 32'(bus.valid_o), 0);
    check("lu_bubble_regwrite", 32'(bus.RegWrite_o), 0);
    check("lu_bubble_memread", 32'(bus.MemRead_o), 0);
    check("lu_stall_cnt", 32'(stall_cnt_o), 1);
    check("lu_stall_after", 32'(stall_o), 0);
    step();
    check("lu_cap_valid", 32'(bus.valid_o), 1);
    check("lu_cap_waddr", 32'(bus.RegWaddr_o), 5);
    check("lu_cap_stall_cnt", 32'(stall_cnt_o), 1);

    // ---- load-use on rt: lw $4 ; add $5,$1,$4
    drive_lw(5'd4, 5'd1);
    step();
    drive_rtype(5'd5, 5'd1, 5'd4, 32'h11, 32'h22);
    settle();
    check("rt_stall", 32'(stall_o), 1);
    step();
    check("rt_stall_cnt", 32'(stall_cnt_o), 2);
    step();

    // ---- rt not used: addi with rt=4, rs=4 stalls on rs; rs=0 does not stall
    drive_lw(5'd4, 5'd1);
    step();
    drive_addi(5'd4, 5'd4);
    settle();
    check("addi_rs_stall", 32'(stall_o), 1);
    step();
    check("addi_stall_cnt", 32'(stall_cnt_o), 3);
    step();
    drive_lw(5'd4, 5'd1);
    step();
    drive_addi(5'd4, 5'd0);
    settle();
    check("addi_rt_only_stall", 32'(stall_o), 0);
    step();
    check("addi_cap_valid", 32'(bus.valid_o), 1);
    check("addi_cap_alusrc", 32'(bus.ALUSrc_o), 1);
    check("addi_cap_stall_cnt", 32'(stall_cnt_o), 3);

    // ---- load into $0 never stalls
    drive_lw(5'd0, 5'd1);
    step();
    drive_rtype(5'd5, 5'd0, 5'd0, 32'h1, 32'h2);
    settle();
    check("lw_r0_stall", 32'(stall_o), 0);
    step();

    // ---- flush and hazard together: flush wins
    drive_lw(5'd4, 5'd1);
    step();
    drive_rtype(5'd5, 5'd4, 5'd1, 32'h11, 32'h22);
    flush_i = 1;
    settle();
    check("fh_stall", 32'(stall_o), 0);
    step();
    check("fh_valid", 32'(bus.valid_o), 0);
    check("fh_regwrite", 32'(bus.RegWrite_o), 0);
    check("fh_flush_cnt", 32'(flush_cnt_o), 1);
    check("fh_stall_cnt", 32'(stall_cnt_o), 3);

    // ---- flush of an invalid slot does not count
    drive_clear();
    step();
    check("fi_flush_cnt", 32'(flush_cnt_o), 1);
    flush_i = 0;

    // ---- start_i=0 freezes everything and masks stall_o
    drive_lw(5'd4, 5'd1);
    step();
    start_i = 0; flush_i = 1;
    drive_rtype(5'd5, 5'd4, 5'd1, 32'h11, 32'h22);
    settle();
    check("hold_stall", 32'(stall_o), 0);
    step();
    check("hold_waddr", 32'(bus.RegWaddr_o), 4);
    check("hold_memread", 32'(bus.MemRead_o), 1);
    check("hold_valid", 32'(bus.valid_o), 1);
    check("hold_flush_cnt", 32'(flush_cnt_o), 1);
    check("hold_stall_cnt", 32'(stall_cnt_o), 3);
    start_i = 1; flush_i = 0;
    drive_clear();
    step();

    // ---- invalid capture forces control to zero but carries data
    drive_rtype(5'd9, 5'd1, 5'd2, 32'h1, 32'h2);
    bus.valid_i = 0; bus.pc_i = 32'h200;
    step();
    check("inv_valid", 32'(bus.valid_o), 0);
    check("inv_regwrite", 32'(bus.RegWrite_o), 0);
    check("inv_aluop", 32'(bus.ALUOp_o), 0);
    check("inv_regdst", 32'(bus.RegDst_o), 0);
    check("inv_pc", bus.pc_o, 32'h200);
    check("inv_waddr", 32'(bus.RegWaddr_o), 9);

    // ---- WB write-through
    drive_rtype(5'd7, 5'd2, 5'd3, 32'h1, 32'h33);
    bus.wb_RegWrite_i = 1; bus.wb_RegWaddr_i = 5'd2; bus.wb_data_i = 32'hDEAD;
    step();
    check("byp_rs", bus.RSdata_o, 32'hDEAD);
    check("byp_rs_rt", bus.RTdata_o, 32'h33);
    bus.wb_RegWaddr_i = 5'd3; bus.wb_data_i = 32'hBEEF;
    step();
    check("byp_rt_rs", bus.RSdata_o, 32'h1);
    check("byp_rt", bus.RTdata_o, 32'hBEEF);
    drive_rtype(5'd7, 5'd0, 5'd3, 32'h11, 32'h22);
    bus.wb_RegWaddr_i = 5'd0; bus.wb_data_i = 32'hDEAD;
    step();
    check("byp_r0_rs", bus.RSdata_o, 32'h11);
    check("byp_r0_rt", bus.RTdata_o, 32'h22);
    bus.wb_RegWrite_i = 0; bus.wb_RegWaddr_i = 5'd3;
    step();
    check("byp_we0_rt", bus.RTdata_o, 32'h22);
    drive_clear();
    step();

    // ---- stall counter saturation: 3 + 16 stalls clamps at 15
    for (int i = 0; i < 16; i++) begin
      drive_lw(5'd4, 5'd1);
      step();
      drive_rtype(5'd5, 5'd4, 5'd1, 32'h11, 32'h22);
      step();
      step();
      if (i == 11) check("sat_stall_cnt_edge", 32'(stall_cnt_o), 15);
    end
    check("sat_stall_cnt", 32'(stall_cnt_o), 15);

    // ---- flush counter saturation: 1 + 20 flushes clamps at 15
    drive_rtype(5'd5, 5'd1, 5'd2, 32'h11, 32'h22);
    flush_i = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_flush_cnt", 32'(flush_cnt_o), 15);
    check("sat_flush_stall_cnt", 32'(stall_cnt_o), 15);
    flush_i = 0;
    drive_clear();
    step();

    // ---- reset in the middle of a stall
    drive_lw(5'd4, 5'd1);
    step();
    drive_rtype(5'd5, 5'd4, 5'd1, 32'h11, 32'h22);
    settle();
    check("rms_stall_before", 32'(stall_o), 1);
    rst_i = 0;
    step();
    check("rms_stall", 32'(stall_o), 0);
    check("rms_valid", 32'(bus.valid_o), 0);
    check("rms_waddr", 32'(bus.RegWaddr_o), 0);
    check("rms_stall_cnt", 32'(stall_cnt_o), 0);
    check("rms_flush_cnt", 32'(flush_cnt_o), 0);
    rst_i = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
